// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed image (sync, word count, data, checksum),
// writes it word by word into instruction memory and answers ACK/NAK.
module uart_boot_loader #(
  parameter int ADDR_W       = 12,
  parameter int TIMEOUT_CLKS = 27000000
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Tx_Active,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  output logic              o_Mem_Wr_En,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [31:0]       o_Mem_Wr_Data,
  output logic              o_Cpu_Reset,
  output logic              o_Done,
  output logic              o_Error,
  output logic [2:0]        o_State
);

  // Handshake: i_Rx_DV and o_Tx_DV are single-cycle strobes with no back-pressure;
  // o_Tx_DV is only raised in a cycle where i_Tx_Active was sampled low.

  localparam int          TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  SYNC     = 8'hA5;
  localparam logic [7:0]  ACK      = 8'h06;
  localparam logic [7:0]  NAK      = 8'h15;
  // Largest word count the memory can hold; a 16-bit count can never exceed it when ADDR_W >= 16.
  localparam logic [16:0] MAX_N    = (ADDR_W >= 16) ? 17'h10000 : (17'd1 << ADDR_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [15:0]       words_rem_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       word_q;
  logic [7:0]        csum_q;
  logic [TW-1:0]     tmo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        resp_q;

  logic [15:0] rx_len;
  logic        too_long;
  logic        active;
  logic        tmo_hit;
  logic        word_done;
  logic        resp_load;
  logic [7:0]  resp_val;

  assign rx_len    = {len_hi_q, i_Rx_Byte};
  assign too_long  = {1'b0, rx_len} > MAX_N;
  assign active    = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA)   || (state_q == CHECK);
  // A byte arriving in the timeout cycle takes priority over the timeout.
  assign tmo_hit   = active && !i_Rx_DV && (tmo_q == TMO_LAST);
  assign word_done = (state_q == DATA) && i_Rx_DV && (byte_cnt_q == 2'd3);
  assign o_State   = state_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    resp_load = 1'b0;
    resp_val  = NAK;
    case (state_q)
      IDLE:   if (i_Rx_DV && i_Rx_Byte == SYNC) state_d = LEN_HI;
      LEN_HI: if (i_Rx_DV) state_d = LEN_LO;
      LEN_LO: begin
        if (i_Rx_DV) begin
          if (rx_len == 16'd0) begin
            state_d = CHECK;
          end else if (too_long) begin
            state_d   = RESP;
            resp_load = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA:   if (word_done && words_rem_q == 16'd1) state_d = CHECK;
      CHECK: begin
        if (i_Rx_DV) begin
          state_d   = RESP;
          resp_load = 1'b1;
          resp_val  = (i_Rx_Byte == csum_q) ? ACK : NAK;
        end
      end
      RESP:   if (!i_Tx_Active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) begin
      state_d   = RESP;
      resp_load = 1'b1;
      resp_val  = NAK;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      len_hi_q      <= 8'd0;
      words_rem_q   <= 16'd0;
      byte_cnt_q    <= 2'd0;
      word_q        <= 24'd0;
      csum_q        <= 8'd0;
      tmo_q         <= '0;
      addr_q        <= '0;
      resp_q        <= 8'd0;
      o_Tx_DV       <= 1'b0;
      o_Tx_Byte     <= 8'd0;
      o_Mem_Wr_En   <= 1'b0;
      o_Mem_Addr    <= '0;
      o_Mem_Wr_Data <= 32'd0;
      o_Cpu_Reset   <= 1'b0;
      o_Done        <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      o_Tx_DV     <= 1'b0;
      o_Mem_Wr_En <= 1'b0;

      if (!active || i_Rx_DV) tmo_q <= '0;
      else                    tmo_q <= tmo_q + TW'(1);

      if (resp_load) resp_q <= resp_val;

      case (state_q)
        IDLE: begin
          if (i_Rx_DV && i_Rx_Byte == SYNC) begin
            o_Cpu_Reset <= 1'b1;
            o_Done      <= 1'b0;
            o_Error     <= 1'b0;
            addr_q      <= '0;
            byte_cnt_q  <= 2'd0;
            csum_q      <= 8'd0;
          end
        end
        LEN_HI: if (i_Rx_DV) len_hi_q <= i_Rx_Byte;
        LEN_LO: if (i_Rx_DV) words_rem_q <= rx_len;
        DATA: begin
          if (i_Rx_DV) begin
            csum_q     <= csum_q + i_Rx_Byte;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= {i_Rx_Byte, word_q[23:8]};
          end
          if (word_done) begin
            o_Mem_Wr_En   <= 1'b1;
            o_Mem_Addr    <= addr_q;
            o_Mem_Wr_Data <= {i_Rx_Byte, word_q};
            addr_q        <= addr_q + ADDR_W'(1);
            words_rem_q   <= words_rem_q - 16'd1;
          end
        end
        RESP: begin
          if (!i_Tx_Active) begin
            o_Tx_DV   <= 1'b1;
            o_Tx_Byte <= resp_q;
            if (resp_q == ACK) begin
              o_Cpu_Reset <= 1'b0;
              o_Done      <= 1'b1;
            end else begin
              o_Error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed frames, expected writes/responses queued
// by the stimulus and consumed by an independent output monitor.
module tb_uart_boot_loader;

  localparam int ADDR_W = 12;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_dv = 1'b0;
  logic [7:0]        rx_byte = 8'd0;
  logic              tx_active = 1'b0;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [2:0]        state;

  uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_byte),
    .i_Tx_Active  (tx_active),
    .o_Tx_DV      (tx_dv),
    .o_Tx_Byte    (tx_byte),
    .o_Mem_Wr_En  (wr_en),
    .o_Mem_Addr   (mem_addr),
    .o_Mem_Wr_Data(wr_data),
    .o_Cpu_Reset  (cpu_reset),
    .o_Done       (done),
    .o_Error      (error),
    .o_State      (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int fails     = 0;
  int wr_seen   = 0;
  int tx_seen   = 0;
  logic [43:0] exp_wr_q[$];   // {addr, data}
  logic [10:0] exp_tx_q[$];   // {done, error, cpu_reset, byte}
  logic [7:0]  frm[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    tests_run++;
    fails++;
    $display("FAIL %s: got 0x%0h, expected no event", name, act);
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_seen++;
      if (exp_wr_q.size() == 0) flag("unexpected_write", {mem_addr, wr_data});
      else check("mem_write", {mem_addr, wr_data}, exp_wr_q.pop_front());
    end
    if (tx_dv === 1'b1) begin
      tx_seen++;
      if (exp_tx_q.size() == 0) flag("unexpected_tx", {done, error, cpu_reset, tx_byte});
      else check("tx_resp_status", {done, error, cpu_reset, tx_byte}, exp_tx_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_tx_q.size() != 0) && n < 500) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, "_drained"}, 64'(exp_wr_q.size() + exp_tx_q.size()), 64'd0);
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_dv"},     64'(tx_dv),     64'd0);
    check({name, "_tx_byte"},   64'(tx_byte),   64'd0);
    check({name, "_wr_en"},     64'(wr_en),     64'd0);
    check({name, "_addr"},      64'(mem_addr),  64'd0);
    check({name, "_wr_data"},   64'(wr_data),   64'd0);
    check({name, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
    check({name, "_done"},      64'(done),      64'd0);
    check({name, "_error"},     64'(error),     64'd0);
    check({name, "_state"},     64'(state),     64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int wr_before;
    int tx_before;

    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Good two-word frame; data byte sum is 0xAA+0xAA+0xBB+0xCC+0xDD = 0x3B8 -> 0xB8.
    exp_wr_q.push_back({12'h000, 32'h44332211});
    exp_wr_q.push_back({12'h001, 32'hDDCCBBAA});
    exp_tx_q.push_back({1'b1, 1'b0, 1'b0, 8'h06});
    send_byte(8'hA5);
    check("sync_cpu_reset", 64'(cpu_reset), 64'd1);
    frm = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hB8};
    send_frm();
    wait_drain("good_frame");
    check("good_state_idle", 64'(state), 64'd0);

    // Same data, wrong checksum: writes still happen, then NAK.
    exp_wr_q.push_back({12'h000, 32'h44332211});
    exp_wr_q.push_back({12'h001, 32'hDDCCBBAA});
    exp_tx_q.push_back({1'b0, 1'b1, 1'b1, 8'h15});
    send_byte(8'hA5);
    check("sync_clears_done", 64'(done), 64'd0);
    check("sync_sets_cpu_reset", 64'(cpu_reset), 64'd1);
    frm = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h9D};
    send_frm();
    wait_drain("bad_csum");

    // Zero-length frame: checksum 0 -> ACK, no writes.
    exp_tx_q.push_back({1'b1, 1'b0, 1'b0, 8'h06});
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frm();
    wait_drain("zero_len");

    // 0x1001 words exceeds 4096 -> NAK straight after LEN_LO.
    exp_tx_q.push_back({1'b0, 1'b1, 1'b1, 8'h15});
    frm = '{8'hA5, 8'h10, 8'h01};
    send_frm();
    wait_drain("too_long");

    // Timeout: one data byte then silence.
    wr_before = wr_seen;
    exp_tx_q.push_back({1'b0, 1'b1, 1'b1, 8'h15});
    frm = '{8'hA5, 8'h00, 8'h01, 8'h11};
    send_frm();
    n = 0;
    while (!(tx_dv === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n < 100 || n > 102) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles, expected 100..102", n);
    end
    repeat (3) @(negedge clk);
    check("timeout_state_idle", 64'(state), 64'd0);
    check("timeout_no_write", 64'(wr_seen - wr_before), 64'd0);
    wait_drain("timeout");

    // Transmitter busy: response withheld, sync byte in RESP ignored.
    exp_wr_q.push_back({12'h000, 32'h04030201});
    frm = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frm();
    tx_active = 1'b1;
    send_byte(8'h0A);
    send_byte(8'hA5);
    repeat (20) @(negedge clk);
    check("resp_held", 64'(state), 64'd5);
    tx_before = tx_seen;
    exp_tx_q.push_back({1'b1, 1'b0, 1'b0, 8'h06});
    @(posedge clk); #1;
    tx_active = 1'b0;
    wait_drain("tx_busy");
    check("tx_single_pulse", 64'(tx_seen - tx_before), 64'd1);
    check("resp_a5_ignored", 64'(state), 64'd0);
    check("tx_byte_stable", 64'(tx_byte), 64'h06);

    // Junk in IDLE, then reset in the middle of DATA.
    wr_before = wr_seen;
    frm = '{8'h00, 8'h5A};
    send_frm();
    repeat (2) @(negedge clk);
    check("idle_junk_state", 64'(state), 64'd0);
    check("idle_junk_no_write", 64'(wr_seen - wr_before), 64'd0);
    exp_wr_q.push_back({12'h000, 32'h44332211});
    frm = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frm();
    wait_drain("partial");
    check("partial_in_data", 64'(state), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_wr_q.push_back({12'h000, 32'h04030201});
    exp_tx_q.push_back({1'b1, 1'b0, 1'b0, 8'h06});
    frm = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_frm();
    wait_drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
